// File: rtl/sccb_slave.sv
// SCCB (I2C-compatible) target: oversamples SIOC/SIOD on i_clk, decodes START/STOP and
// id/register/data bytes, and exposes an external register port for writes and reads.
module sccb_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h21
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_scl,
    inout  wire        io_sda,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_wr_data,
    output logic       o_wr_en,
    output logic       o_rd_en,
    input  logic [7:0] i_rd_data,
    output logic       o_busy
);
    typedef enum logic [3:0] {
        IDLE, DEV_ID, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK,
        RD_LOAD, RD_DATA, RD_MACK, WAIT_STOP
    } state_t;

    state_t      state_q;
    logic [2:0]  scl_sync_q, sda_sync_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  shift_q, reg_addr_q, wr_data_q;
    logic        sda_oe_q, rw_q, first_q, wr_en_q, rd_en_q, busy_q;

    // [1] is the synchronized level, [2] its one-cycle history; idle bus level is high
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            scl_sync_q <= 3'b111;
            sda_sync_q <= 3'b111;
        end else begin
            scl_sync_q <= {scl_sync_q[1:0], i_scl};
            sda_sync_q <= {sda_sync_q[1:0], io_sda};
        end
    end

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_sync_q[2];
    assign scl_fall  = ~scl_s & scl_sync_q[2];
    assign start_det = scl_s & ~sda_s & sda_sync_q[2];
    assign stop_det  = scl_s & sda_s & ~sda_sync_q[2];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            reg_addr_q <= 8'h00;
            wr_data_q  <= 8'h00;
            sda_oe_q   <= 1'b0;
            rw_q       <= 1'b0;
            first_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            if (start_det) begin
                state_q   <= DEV_ID;
                bit_cnt_q <= 4'd0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b1;
            end else if (stop_det) begin
                state_q  <= IDLE;
                sda_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                case (state_q)
                    DEV_ID, REG_ADDR, WR_DATA: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], sda_s};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q <= 4'd0;
                            sda_oe_q  <= 1'b1;
                            if (state_q == DEV_ID) begin
                                rw_q <= shift_q[0];
                                if (shift_q[7:1] == DEV_ADDR) begin
                                    state_q <= DEV_ACK;
                                end else begin
                                    state_q  <= WAIT_STOP;
                                    sda_oe_q <= 1'b0;
                                end
                            end else if (state_q == REG_ADDR) begin
                                reg_addr_q <= shift_q;
                                state_q    <= REG_ACK;
                            end else begin
                                // later bytes of a burst advance the pointer with the strobe
                                if (!first_q) reg_addr_q <= reg_addr_q + 8'd1;
                                first_q   <= 1'b0;
                                wr_data_q <= shift_q;
                                wr_en_q   <= 1'b1;
                                state_q   <= WR_ACK;
                            end
                        end
                    end
                    DEV_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            if (rw_q) begin
                                rd_en_q <= 1'b1;
                                state_q <= RD_LOAD;
                            end else begin
                                state_q <= REG_ADDR;
                            end
                        end
                    end
                    REG_ACK, WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            first_q  <= (state_q == REG_ACK);
                            state_q  <= WR_DATA;
                        end
                    end
                    RD_LOAD: begin
                        // fetched data arrives the cycle after the strobe; bit 7 goes out at once
                        if (rd_en_q) begin
                            shift_q   <= i_rd_data;
                            sda_oe_q  <= ~i_rd_data[7];
                            bit_cnt_q <= 4'd0;
                            state_q   <= RD_DATA;
                        end else if (scl_fall) begin
                            rd_en_q <= 1'b1;
                        end
                    end
                    RD_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == 4'd7) begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= 4'd0;
                                state_q   <= RD_MACK;
                            end else begin
                                shift_q   <= {shift_q[6:0], 1'b0};
                                sda_oe_q  <= ~shift_q[6];
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    RD_MACK: begin
                        if (scl_rise) begin
                            if (sda_s) begin
                                state_q <= WAIT_STOP;
                            end else begin
                                reg_addr_q <= reg_addr_q + 8'd1;
                                state_q    <= RD_LOAD;
                            end
                        end
                    end
                    default: sda_oe_q <= 1'b0;
                endcase
            end
        end
    end

    assign io_sda     = sda_oe_q ? 1'b0 : 1'bz;
    assign o_reg_addr = reg_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_wr_en    = wr_en_q;
    assign o_rd_en    = rd_en_q;
    assign o_busy     = busy_q;
endmodule

// File: tb/tb_sccb_slave.sv
// Directed bench for sccb_slave: a bit-level SCCB master drives the bus, register-port
// strobes are checked against queues of expected (addr, data) and read addresses.
`timescale 1ns/1ps
module tb_sccb_slave;
    localparam int Q = 100;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] rd_data = 8'h00;
    wire        sda;
    logic [7:0] reg_addr, wr_data;
    logic       wr_en, rd_en, busy;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    sccb_slave #(.DEV_ADDR(7'h21)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_scl(scl), .io_sda(sda),
        .o_reg_addr(reg_addr), .o_wr_data(wr_data), .o_wr_en(wr_en),
        .o_rd_en(rd_en), .i_rd_data(rd_data), .o_busy(busy)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // strobe scoreboard
    always @(negedge clk) begin
        if (wr_en) begin
            chk("wr_expected", 16'(wr_q.size() != 0), 16'd1);
            if (wr_q.size() != 0) chk("wr_addr_data", {reg_addr, wr_data}, wr_q.pop_front());
        end
        if (rd_en) begin
            chk("rd_expected", 16'(rd_q.size() != 0), 16'd1);
            if (rd_q.size() != 0) chk("rd_addr", {8'h00, reg_addr}, {8'h00, rd_q.pop_front()});
        end
    end

    task automatic start_c();
        m_low = 1'b0; #Q scl = 1'b1; #Q m_low = 1'b1; #Q scl = 1'b0; #Q;
    endtask

    task automatic stop_c();
        m_low = 1'b1; #Q scl = 1'b1; #Q m_low = 1'b0; #Q;
    endtask

    task automatic bits_w(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_low = ~b[i]; #Q scl = 1'b1; #(2*Q) scl = 1'b0; #Q;
        end
    endtask

    task automatic wr_byte(input logic [7:0] b, input string tag, input logic exp_ack);
        logic a;
        bits_w(b, 8);
        m_low = 1'b0; #Q scl = 1'b1; #Q a = sda; #Q scl = 1'b0; #Q;
        chk(tag, {15'd0, a}, {15'd0, exp_ack});
    endtask

    task automatic rd_byte(output logic [7:0] b, input logic nack);
        b = 8'h00;
        m_low = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #Q scl = 1'b1; #Q b = {b[6:0], sda}; #Q scl = 1'b0; #Q;
        end
        m_low = ~nack; #Q scl = 1'b1; #(2*Q) scl = 1'b0; #Q m_low = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        #53;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_wr_en", {15'd0, wr_en}, 16'd0);
        chk("rst_rd_en", {15'd0, rd_en}, 16'd0);
        chk("rst_reg_addr", {8'd0, reg_addr}, 16'h0000);
        chk("rst_wr_data", {8'd0, wr_data}, 16'h0000);
        chk("rst_sda", {15'd0, sda}, 16'd1);
        rstn = 1'b1;
        #200;

        // 3-phase write
        start_c();
        chk("busy_after_start", {15'd0, busy}, 16'd1);
        wr_byte(8'h42, "w3_id_ack", 1'b0);
        wr_byte(8'h12, "w3_addr_ack", 1'b0);
        wr_q.push_back({8'h12, 8'h80});
        wr_byte(8'h80, "w3_data_ack", 1'b0);
        stop_c();
        chk("busy_after_stop", {15'd0, busy}, 16'd0);

        // foreign id: never acknowledged, no strobes
        start_c();
        wr_byte(8'h60, "bad_id_nack", 1'b1);
        wr_byte(8'h12, "bad_addr_nack", 1'b1);
        stop_c();

        // 2-phase write then read with master NA
        start_c();
        wr_byte(8'h42, "r_id_ack", 1'b0);
        wr_byte(8'h0A, "r_addr_ack", 1'b0);
        stop_c();
        rd_data = 8'h76;
        rd_q.push_back(8'h0A);
        start_c();
        wr_byte(8'h43, "r_rid_ack", 1'b0);
        rd_byte(b, 1'b1);
        chk("r_data", {8'd0, b}, 16'h0076);
        stop_c();

        // burst write across the 8'hFF wrap
        start_c();
        wr_byte(8'h42, "b_id_ack", 1'b0);
        wr_byte(8'hFF, "b_addr_ack", 1'b0);
        wr_q.push_back({8'hFF, 8'h11});
        wr_q.push_back({8'h00, 8'h22});
        wr_byte(8'h11, "b_d0_ack", 1'b0);
        wr_byte(8'h22, "b_d1_ack", 1'b0);
        stop_c();
        chk("b_addr_final", {8'd0, reg_addr}, 16'h0000);

        // repeated START after the register address, then read
        start_c();
        wr_byte(8'h42, "rs_id_ack", 1'b0);
        wr_byte(8'h33, "rs_addr_ack", 1'b0);
        rd_data = 8'h5A;
        rd_q.push_back(8'h33);
        start_c();
        wr_byte(8'h43, "rs_rid_ack", 1'b0);
        rd_byte(b, 1'b1);
        chk("rs_data", {8'd0, b}, 16'h005A);
        stop_c();

        // reset while the slave drives a read data bit
        rd_data = 8'h76;
        rd_q.push_back(8'h33);
        start_c();
        wr_byte(8'h43, "rr_rid_ack", 1'b0);
        #Q;
        chk("rr_bit7_driven", {15'd0, sda}, 16'd0);
        rstn = 1'b0;
        #1;
        chk("rr_sda_released", {15'd0, sda}, 16'd1);
        chk("rr_busy", {15'd0, busy}, 16'd0);
        chk("rr_reg_addr", {8'd0, reg_addr}, 16'h0000);
        #20 rstn = 1'b1;
        #Q scl = 1'b1;
        #(2*Q);
        start_c();
        wr_byte(8'h42, "pr_id_ack", 1'b0);
        wr_byte(8'h07, "pr_addr_ack", 1'b0);
        wr_q.push_back({8'h07, 8'h3C});
        wr_byte(8'h3C, "pr_data_ack", 1'b0);
        stop_c();
        #(2*Q);

        chk("wr_queue_drained", 16'(wr_q.size()), 16'd0);
        chk("rd_queue_drained", 16'(rd_q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sccb_slave.md
# sccb_slave

Synthesizable SCCB (I2C-compatible, OV7670-style) target that answers transactions from `sccb_master`. It serves as a camera-register stand-in for closed-loop simulation and for FPGA-to-FPGA bring-up. It oversamples SIOC/SIOD on the system clock, decodes START/STOP, device address, register address and data bytes, and drives ACK and read data open-drain. Register storage is external: the block issues write strobes and fetches read data through a simple register port.

## Interface
- `DEV_ADDR`, 7'h21: 7-bit device address the block answers to.
- `i_clk` input 1: system clock, 100 MHz; must be ≥16× SCL frequency.
- `i_rstn` input 1: asynchronous active-low reset.
- `i_scl` input 1: SCCB clock from the master, asynchronous.
- `io_sda` inout 1: SCCB data, open-drain; driven only as 0 or Z.
- `o_reg_addr` output 8: current register address pointer.
- `o_wr_data` output 8: write data, valid while `o_wr_en` is high.
- `o_wr_en` output 1: one-cycle register write strobe.
- `o_rd_en` output 1: one-cycle read-fetch strobe for `o_reg_addr`.
- `i_rd_data` input 8: register read data, valid on the `i_clk` after `o_rd_en`.
- `o_busy` output 1: high from a detected START until the STOP.

## Operation
- Input conditioning: SCL and SDA each pass through a 2-flop synchronizer plus one history flop, giving rise and fall detection.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognized in every state.
  - START always enters DEV_ID and clears the bit counter (this covers repeated START).
  - STOP always enters IDLE and releases SDA.
- Bit transfer: the block samples SDA on SCL rise and changes its own SDA drive only on SCL fall. Bytes are MSB first.
- States: IDLE, DEV_ID, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_LOAD, RD_DATA, RD_MACK, WAIT_STOP.
- DEV_ID, 8 bits: compare bits [7:1] with DEV_ADDR.
  - Mismatch → WAIT_STOP; SDA is never driven.
  - Match, R/W=0 → DEV_ACK → REG_ADDR.
  - Match, R/W=1 → DEV_ACK → RD_LOAD.
- ACK phases (DEV_ACK, REG_ACK, WR_ACK): pull SDA low from the SCL fall after bit 8 until the next SCL fall (the 9th clock). Release SDA on that fall.
- REG_ADDR: load the byte into `o_reg_addr`, then REG_ACK → WR_DATA. A STOP here ends a 2-phase write; the pointer is kept for a later read.
- WR_DATA: on the SCL fall after bit 8, place the byte on `o_wr_data` and pulse `o_wr_en` once. Then WR_ACK → WR_DATA.
  - Each subsequent data byte first increments `o_reg_addr` (wraps 8'hFF→8'h00), then writes.
- RD_LOAD: pulse `o_rd_en` on the SCL fall that ends DEV_ACK. Capture `i_rd_data` into the shift register on the next `i_clk`, and drive bit 7 immediately.
- RD_DATA: drive a 0 bit as low and a 1 bit as Z. Shift on each SCL fall. Release SDA after 8 bits.
- RD_MACK: sample the master's 9th bit on SCL rise.
  - 1 (NA) → WAIT_STOP.
  - 0 → increment `o_reg_addr` (with wrap) → RD_LOAD.
- WAIT_STOP: SDA released; wait for STOP or START.
- Reset, asserted at any time including mid-byte, immediately forces IDLE with SDA released.

## Timing
- Reset values: SDA released (Z), `o_wr_en`=0, `o_rd_en`=0, `o_busy`=0, `o_reg_addr`=8'h00, `o_wr_data`=8'h00, bit counter 0.
- Detection latency: 3 `i_clk` from a pin edge to internal edge detection (30 ns at 100 MHz). SDA drive changes on the cycle after detection, i.e. well inside SCL low time.
- `o_wr_en` asserts 3–4 `i_clk` after the SCL fall that ends data bit 8. `o_wr_data` and `o_reg_addr` are stable during the strobe.
- `o_rd_en` to `i_rd_data` capture: exactly 1 `i_clk`.
- `o_busy` rises on START detection and falls on STOP detection or reset.
- SDA changes while SCL is high are only ever START or STOP. The block never drives SDA while SCL is high, except to hold an ACK or data bit already in progress.

## Test plan
- 3-phase write with id 8'h42, addr 8'h12, data 8'h80, using `sccb_master` → three ACK-low 9th clocks; a single `o_wr_en` with `o_reg_addr`=8'h12 and `o_wr_data`=8'h80.
- Wrong id 8'h60 → SDA never driven low; no `o_wr_en`/`o_rd_en`; the next valid transaction is accepted.
- Read: 2-phase write 8'h42, 8'h0A, STOP; then START, 8'h43 with `i_rd_data`=8'h76, master NA → one `o_rd_en` at addr 8'h0A; bits 0,1,1,1,0,1,1,0 appear on SDA.
- Burst write from addr 8'hFF with data 8'h11, 8'h22 → writes (8'hFF, 8'h11) then (8'h00, 8'h22).
- Repeated START after REG_ADDR, followed by a read id → no write strobe; read proceeds from the latched address.
- `i_rstn` pulsed low mid-data-byte → SDA released and `o_busy`=0 at once; the following full write succeeds.
